// File: rtl/edge_capture_pkg.sv
// Shared types and constants for the edge event capture block and its event FIFO.
package edge_capture_pkg;

    localparam int TS_W_DEFAULT     = 16;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int FIFO_DEPTH       = 2;

    // Event layout at the default timestamp width; the top rebuilds the same layout for any TS_W.
    typedef struct packed {
        logic                    rising;
        logic [TS_W_DEFAULT-1:0] stamp;
    } event_t;

    localparam int EVENT_W = $bits(event_t);

endpackage

// File: rtl/event_fifo2.sv
// Two-entry in-order event FIFO; a push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module event_fifo2
    import edge_capture_pkg::*;
#(
    parameter int W = EVENT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/edge_event_capture.sv
// Debounces a raw input through a two-stage history chain and queues each accepted
// level change as a timestamped event for a valid/ready consumer.
module edge_event_capture
    import edge_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int TS_W            = TS_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            signal_in,
    input  logic            event_ready,
    input  logic            overflow_clear,
    output logic            level_out,
    output logic            event_valid,
    output logic            event_rising,
    output logic [TS_W-1:0] event_time,
    output logic            overflow
);

    typedef struct packed {
        logic            rising;
        logic [TS_W-1:0] stamp;
    } ev_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            p1_sig;
    logic            p2_sig;
    logic            level;
    logic [CNT_W-1:0] cnt;
    logic [TS_W-1:0] timestamp;
    logic            overflow_r;

    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    ev_t             push_ev;
    ev_t             head_ev;

    // Valid/ready: a head event transfers on any edge where event_valid and event_ready are
    // both high; while valid is high and ready is low the head fields are held unchanged.
    assign push    = (p2_sig != level) && (cnt == CNT_LAST);
    assign pop     = ~fifo_empty & event_ready;
    assign drop    = push & fifo_full & ~pop;
    assign push_ev = '{rising: p2_sig, stamp: timestamp};

    // p1_sig/p2_sig double as the synchronizer for the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_sig     <= 1'b0;
            p2_sig     <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            timestamp  <= '0;
            overflow_r <= 1'b0;
        end else begin
            p1_sig    <= signal_in;
            p2_sig    <= p1_sig;
            timestamp <= timestamp + 1'b1;

            if (p2_sig == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= p2_sig;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_r <= 1'b1;
            end else if (overflow_clear) begin
                overflow_r <= 1'b0;
            end
        end
    end

    event_fifo2 #(
        .W($bits(ev_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_ev),
        .rdata (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign level_out    = level;
    assign event_valid  = ~fifo_empty;
    assign event_rising = ~fifo_empty & head_ev.rising;
    assign event_time   = fifo_empty ? '0 : head_ev.stamp;
    assign overflow     = overflow_r;

endmodule
